// File: rtl/gray_pkg.sv
// Shared widths, FSM state encoding and step classes for the Gray sequence checker.
package gray_pkg;

    localparam int N_DEF        = 4;
    localparam int LOCK_CNT_DEF = 3;
    localparam int CNT_W_DEF    = 8;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        STEP = 2'd1,
        BAD  = 2'd2
    } step_t;

endpackage

// File: rtl/gray_seq_checker_gray2bin.sv
// Combinational Gray-to-binary decode: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
    parameter int N = 4
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    always_comb begin
        bin        = '0;
        bin[N-1]   = gray[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

endmodule

// File: rtl/gray_seq_checker.sv
// Gray counter receive-side monitor: decodes each strobed sample, tracks lock on +1 steps,
// and flags step errors, counts them (saturating) and reports wrap-around.
module gray_seq_checker
    import gray_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic [N-1:0]     gray_in,
    output logic [N-1:0]     bin_out,
    output logic             bin_valid,
    output logic             locked,
    output logic             step_err,
    output logic [CNT_W-1:0] err_count,
    output logic             wrap_pulse
);

    localparam int           GW      = $clog2(LOCK_CNT + 1);
    localparam logic [N-1:0] BIN_MAX = {N{1'b1}};

    logic [N-1:0]     bin_dec;
    logic [N-1:0]     prev;
    step_t            cls;
    state_t           state, state_nxt;
    logic [GW-1:0]    good_cnt, good_nxt;
    logic [CNT_W-1:0] err_nxt;
    logic             step_err_nxt;
    logic             wrap_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    gray2bin #(.N(N)) u_gray2bin (
        .gray (gray_in),
        .bin  (bin_dec)
    );

    // The +1 comparison is done in N bits so 2^N-1 -> 0 counts as a valid step.
    always_comb begin
        cls = BAD;
        if (bin_dec == prev) begin
            cls = HOLD;
        end else if (bin_dec == prev + N'(1)) begin
            cls = STEP;
        end
    end

    always_comb begin
        state_nxt    = state;
        good_nxt     = good_cnt;
        err_nxt      = err_count;
        step_err_nxt = 1'b0;
        wrap_nxt     = 1'b0;
        if (sample_en) begin
            unique case (state)
                UNLOCKED: begin
                    state_nxt = LOCKING;
                    good_nxt  = '0;
                end
                LOCKING: begin
                    if (cls == STEP) begin
                        good_nxt = good_cnt + GW'(1);
                        if (good_cnt == GW'(LOCK_CNT - 1)) begin
                            state_nxt = LOCKED;
                        end
                    end else if (cls == BAD) begin
                        good_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (cls == STEP) begin
                        wrap_nxt = (prev == BIN_MAX) && (bin_dec == '0);
                    end else if (cls == BAD) begin
                        step_err_nxt = 1'b1;
                        err_nxt      = sat_inc(err_count);
                        good_nxt     = '0;
                        state_nxt    = LOCKING;
                    end
                end
                default: state_nxt = UNLOCKED;
            endcase
        end
    end

    // Single register stage: everything reflects the sample taken on this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= UNLOCKED;
            good_cnt   <= '0;
            prev       <= '0;
            err_count  <= '0;
            bin_valid  <= 1'b0;
            step_err   <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            good_cnt   <= good_nxt;
            err_count  <= err_nxt;
            bin_valid  <= sample_en;
            step_err   <= step_err_nxt;
            wrap_pulse <= wrap_nxt;
            if (sample_en) begin
                prev <= bin_dec;
            end
        end
    end

    assign bin_out = prev;
    assign locked  = (state == LOCKED);

endmodule

// File: tb/tb_gray_seq_checker.sv
// Randomized and directed bench for gray_seq_checker (N=4, LOCK_CNT=3, CNT_W=2) with a table-driven reference model.
module tb_gray_seq_checker;

    localparam int N        = 4;
    localparam int LOCK_CNT = 3;
    localparam int CNT_W    = 2;
    localparam int MODV     = 1 << N;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             sample_en = 1'b0;
    logic [N-1:0]     gray_in = '0;
    logic [N-1:0]     bin_out;
    logic             bin_valid;
    logic             locked;
    logic             step_err;
    logic [CNT_W-1:0] err_count;
    logic             wrap_pulse;

    gray_seq_checker #(.N(N), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (sample_en),
        .gray_in    (gray_in),
        .bin_out    (bin_out),
        .bin_valid  (bin_valid),
        .locked     (locked),
        .step_err   (step_err),
        .err_count  (err_count),
        .wrap_pulse (wrap_pulse)
    );

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int mis_cnt = 0;

    // Reference model state
    int   dec_tab[MODV];
    bit   started;
    int   m_prev;
    int   m_good;
    bit   m_locked;
    int   m_errs;
    bit   e_valid, e_err, e_wrap;
    logic [N+CNT_W+3:0] exp_vec;
    logic [N+CNT_W+3:0] act_vec;

    assign act_vec = {bin_out, bin_valid, step_err, wrap_pulse, locked, err_count};

    function automatic logic [N-1:0] g_of(input int b);
        int v;
        v = b % MODV;
        return N'(v ^ (v >> 1));
    endfunction

    function automatic logic [N+CNT_W+3:0] model_vec();
        return {N'(m_prev), e_valid, e_err, e_wrap, m_locked, CNT_W'(m_errs)};
    endfunction

    task automatic model_reset();
        started  = 0;
        m_prev   = 0;
        m_good   = 0;
        m_locked = 0;
        m_errs   = 0;
        e_valid  = 0;
        e_err    = 0;
        e_wrap   = 0;
        exp_vec  = model_vec();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        sample_en = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Drives one cycle and advances the model; comparisons happen in the calling test.
    task automatic drive(input logic en, input logic [N-1:0] g);
        int b;
        @(negedge clk);
        sample_en = en;
        gray_in   = g;
        @(posedge clk);
        #1;
        e_valid = 0;
        e_err   = 0;
        e_wrap  = 0;
        if (en) begin
            b = dec_tab[g];
            e_valid = 1;
            if (!started) begin
                started = 1;
                m_good  = 0;
            end else if (b == m_prev) begin
            end else if (b == (m_prev + 1) % MODV) begin
                if (m_locked) begin
                    e_wrap = (m_prev == MODV - 1) && (b == 0);
                end else begin
                    m_good++;
                    if (m_good == LOCK_CNT) m_locked = 1;
                end
            end else begin
                if (m_locked) begin
                    e_err    = 1;
                    m_errs   = (m_errs < CNT_MAX) ? m_errs + 1 : CNT_MAX;
                    m_locked = 0;
                end
                m_good = 0;
            end
            m_prev = b;
        end
        exp_vec = model_vec();
    endtask

    task automatic test_reset();
        #3;
        cmp_cnt++;
        if (act_vec !== '0) begin
            mis_cnt++;
            $display("FAIL reset_state act=%h exp=0", act_vec);
        end
        do_reset();
        drive(1'b0, 4'b0000);
        cmp_cnt++;
        if (act_vec !== '0) begin
            mis_cnt++;
            $display("FAIL reset_idle act=%h exp=0", act_vec);
        end
    endtask

    task automatic test_lock();
        logic [N-1:0] seq [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, seq[i]);
            cmp_cnt++;
            if (bin_out !== N'(i) || bin_valid !== 1'b1 || step_err !== 1'b0 || err_count !== '0 ||
                locked !== (i == 3)) begin
                mis_cnt++;
                $display("FAIL lock_s%0d act bin=%0d v=%b e=%b cnt=%0d l=%b exp bin=%0d v=1 e=0 cnt=0 l=%b",
                         i, bin_out, bin_valid, step_err, err_count, locked, i, (i == 3));
            end
        end
        drive(1'b0, 4'b0000);
        cmp_cnt++;
        if (act_vec !== exp_vec || bin_valid !== 1'b0 || locked !== 1'b1) begin
            mis_cnt++;
            $display("FAIL lock_idle act=%h exp=%h", act_vec, exp_vec);
        end
    endtask

    task automatic test_wrap();
        for (int b = 4; b <= MODV; b++) begin
            drive(1'b1, g_of(b));
            cmp_cnt++;
            if (act_vec !== exp_vec || wrap_pulse !== (b == MODV)) begin
                mis_cnt++;
                $display("FAIL wrap_b%0d act=%h exp=%h wrap=%b", b, act_vec, exp_vec, wrap_pulse);
            end
        end
        drive(1'b0, 4'b1111);
        cmp_cnt++;
        if (wrap_pulse !== 1'b0 || bin_out !== '0 || locked !== 1'b1) begin
            mis_cnt++;
            $display("FAIL wrap_after act wrap=%b bin=%0d l=%b exp wrap=0 bin=0 l=1", wrap_pulse, bin_out, locked);
        end
    endtask

    task automatic test_skip_error();
        logic [N-1:0] relock [3] = '{4'b0111, 4'b0101, 4'b0100};
        do_reset();
        drive(1'b1, g_of(14));
        drive(1'b1, g_of(15));
        drive(1'b1, g_of(0));
        drive(1'b1, g_of(1));
        cmp_cnt++;
        if (locked !== 1'b1 || bin_out !== 4'd1 || wrap_pulse !== 1'b0) begin
            mis_cnt++;
            $display("FAIL skip_prelock act l=%b bin=%0d wrap=%b exp l=1 bin=1 wrap=0", locked, bin_out, wrap_pulse);
        end
        drive(1'b1, 4'b0110);
        cmp_cnt++;
        if (step_err !== 1'b1 || err_count !== 2'd1 || locked !== 1'b0 || bin_out !== 4'd4) begin
            mis_cnt++;
            $display("FAIL skip_err act e=%b cnt=%0d l=%b bin=%0d exp e=1 cnt=1 l=0 bin=4",
                     step_err, err_count, locked, bin_out);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, relock[i]);
            cmp_cnt++;
            if (act_vec !== exp_vec || locked !== (i == 2) || err_count !== 2'd1 || step_err !== 1'b0) begin
                mis_cnt++;
                $display("FAIL skip_relock%0d act=%h exp=%h", i, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_hold_idle();
        logic [N+CNT_W+3:0] held;
        do_reset();
        drive(1'b1, g_of(15));
        drive(1'b1, g_of(0));
        drive(1'b1, g_of(1));
        drive(1'b1, 4'b0011);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'b0011);
            cmp_cnt++;
            if (bin_valid !== 1'b1 || step_err !== 1'b0 || locked !== 1'b1 || bin_out !== 4'd2) begin
                mis_cnt++;
                $display("FAIL hold_%0d act v=%b e=%b l=%b bin=%0d exp v=1 e=0 l=1 bin=2",
                         i, bin_valid, step_err, locked, bin_out);
            end
        end
        drive(1'b0, 4'b1010);
        held = act_vec;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, N'($urandom));
            cmp_cnt++;
            if (act_vec !== held || act_vec !== exp_vec) begin
                mis_cnt++;
                $display("FAIL idle_%0d act=%h exp=%h", i, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_saturation();
        int exp_err [5] = '{1, 2, 3, 3, 3};
        do_reset();
        for (int b = 0; b < 4; b++) drive(1'b1, g_of(b));
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, g_of(m_prev + 2));
            cmp_cnt++;
            if (step_err !== 1'b1 || err_count !== CNT_W'(exp_err[k]) || act_vec !== exp_vec) begin
                mis_cnt++;
                $display("FAIL sat_%0d act e=%b cnt=%0d exp e=1 cnt=%0d", k, step_err, err_count, exp_err[k]);
            end
            for (int s = 0; s < 3; s++) drive(1'b1, g_of(m_prev + 1));
            cmp_cnt++;
            if (locked !== 1'b1 || act_vec !== exp_vec) begin
                mis_cnt++;
                $display("FAIL sat_relock%0d act=%h exp=%h", k, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int b = 0; b < 4; b++) drive(1'b1, g_of(b));
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, g_of(m_prev + 3));
            for (int s = 0; s < 3; s++) drive(1'b1, g_of(m_prev + 1));
        end
        drive(1'b1, g_of(m_prev + 1));
        cmp_cnt++;
        if (locked !== 1'b1 || err_count !== 2'd2 || bin_valid !== 1'b1) begin
            mis_cnt++;
            $display("FAIL arst_pre act l=%b cnt=%0d v=%b exp l=1 cnt=2 v=1", locked, err_count, bin_valid);
        end
        #1;
        rst = 1'b0;
        #1;
        cmp_cnt++;
        if (act_vec !== '0) begin
            mis_cnt++;
            $display("FAIL arst_clear act=%h exp=0", act_vec);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 4'b0101);
        cmp_cnt++;
        if (locked !== 1'b0 || step_err !== 1'b0 || bin_out !== 4'd6 || bin_valid !== 1'b1) begin
            mis_cnt++;
            $display("FAIL arst_first act l=%b e=%b bin=%0d v=%b exp l=0 e=0 bin=6 v=1",
                     locked, step_err, bin_out, bin_valid);
        end
        drive(1'b1, g_of(3));
        cmp_cnt++;
        if (step_err !== 1'b0 || err_count !== '0 || locked !== 1'b0 || act_vec !== exp_vec) begin
            mis_cnt++;
            $display("FAIL arst_locking act=%h exp=%h", act_vec, exp_vec);
        end
    endtask

    task automatic test_random();
        int r, nb;
        logic en;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r  = int'($urandom_range(99));
            en = ($urandom_range(9) < 8);
            if (r < 60)      nb = m_prev + 1;
            else if (r < 75) nb = m_prev;
            else             nb = int'($urandom_range(MODV - 1));
            drive(en, g_of(nb));
            cmp_cnt++;
            if (act_vec !== exp_vec) begin
                mis_cnt++;
                $display("FAIL rand_%0d act=%h exp=%h", i, act_vec, exp_vec);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < MODV; i++) dec_tab[i ^ (i >> 1)] = i;
        model_reset();
        test_reset();
        test_lock();
        test_wrap();
        test_skip_error();
        test_hold_idle();
        test_saturation();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
